// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, op encoding and widths.
package load_store_unit_pkg;

  localparam int REG_IDX_W = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_WB,
    ST_DONE
  } lsu_state_e;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } lsu_op_e;

  function automatic logic is_word_aligned(input logic [1:0] i_lsb);
    return (i_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/acknowledge bus between the load/store unit and data RAM.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit_timeout_ctr.sv
// Loadable up-counter with clear; o_terminal flags the increment that reaches TIMEOUT.
module lsu_timeout_ctr
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;

  assign w_next     = r_count + CNT_W'(1);
  assign o_terminal = i_en && (w_next == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one LDR/STR at a time toward data RAM and drives the write-back mux
// inputs, delaying the register-bank strobe one cycle to match the mux register.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_is_load,
  input  logic                 i_is_store,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_store_data,
  input  logic [REG_IDX_W-1:0] i_dest_reg,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_ld_sel,
  output logic [DATA_W-1:0]    o_ld_data,
  output logic                 o_wb_en,
  output logic [REG_IDX_W-1:0] o_wb_reg,
  load_store_unit_if.master    mem
);

  lsu_state_e           r_state;
  lsu_state_e           w_nextState;
  lsu_op_e              r_op;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_storeData;
  logic [DATA_W-1:0]    r_ldData;
  logic [REG_IDX_W-1:0] r_destReg;
  logic                 r_err;

  logic w_opValid;
  logic w_aligned;
  logic w_startIdle;
  logic w_accept;
  logic w_startErr;
  logic w_ctrEn;
  logic w_terminal;
  logic w_timeout;

  assign w_opValid   = i_is_load ^ i_is_store;
  assign w_aligned   = is_word_aligned(i_addr[1:0]);
  assign w_startIdle = (r_state == ST_IDLE) && i_start;
  assign w_accept    = w_startIdle && w_opValid && w_aligned;
  assign w_startErr  = w_startIdle && !(w_opValid && w_aligned);
  assign w_ctrEn     = (r_state == ST_REQ);
  // An ack arriving on the terminal cycle completes the access instead of timing out.
  assign w_timeout   = w_ctrEn && !mem.mem_ack && w_terminal;

  lsu_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_accept),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_ctrEn),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          w_nextState = (r_op == OP_LOAD) ? ST_CAPT : ST_DONE;
        end else if (w_terminal) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_CAPT: w_nextState = ST_WB;
      ST_WB:   w_nextState = ST_IDLE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (r_state != ST_IDLE);
    o_done        = 1'b0;
    o_ld_sel      = 1'b0;
    o_wb_en       = 1'b0;
    o_wb_reg      = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (r_state)
      ST_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = (r_op == OP_STORE);
        mem.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem.mem_wdata = r_storeData;
      end
      ST_CAPT: begin
        o_ld_sel = 1'b1;
      end
      ST_WB: begin
        o_ld_sel = 1'b1;
        o_wb_en  = 1'b1;
        o_wb_reg = r_destReg;
        o_done   = 1'b1;
      end
      ST_DONE: begin
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_err     = r_err;
  assign o_ld_data = r_ldData;

  // Transaction latches, load-data capture and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_LOAD;
      r_addr      <= '0;
      r_storeData <= '0;
      r_destReg   <= '0;
      r_ldData    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_startErr || w_timeout;
      if (w_accept) begin
        r_op        <= i_is_load ? OP_LOAD : OP_STORE;
        r_addr      <= i_addr;
        r_storeData <= i_store_data;
        r_destReg   <= i_dest_reg;
      end
      if ((r_state == ST_REQ) && mem.mem_ack && (r_op == OP_LOAD)) begin
        r_ldData <= mem.mem_rdata;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences one LDR/STR at a time between the control unit and data RAM. Holds a request/acknowledge handshake toward RAM, counts a timeout, and captures load data. Drives the write-back select and RAM-data inputs of the write-back mux, timing its register-bank write strobe to match the mux's one-cycle registered output. ALU results bypass this block entirely.

## Interface
Parameters:
- ADDR_W, 32, RAM byte-address width
- DATA_W, 32, data word width
- TIMEOUT, 255, max cycles waiting for mem_ack (1..255)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request from control unit
- is_load  in  1  LDR opcode
- is_store  in  1  STR opcode
- addr  in  ADDR_W  byte address from ALU
- store_data  in  DATA_W  register value to store
- dest_reg  in  4  load destination register index
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse (illegal op, misaligned address, timeout)
- ld_sel  out  1  write-back mux select; 1 selects RAM data
- ld_data  out  DATA_W  captured load word, to mux RAM-data input
- wb_en  out  1  register-bank write strobe for loads
- wb_reg  out  4  register-bank write index
- mem_req  out  1  RAM request, held until mem_ack
- mem_we  out  1  1 = write, valid while mem_req
- mem_addr  out  ADDR_W  word-aligned address, valid while mem_req
- mem_wdata  out  DATA_W  store data, valid while mem_req
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  RAM acknowledge, single cycle

## Operation
- States: IDLE, REQ, CAPT, WB, DONE.
- IDLE: on start:
  - Exactly one of is_load/is_store, and addr[1:0]==0: latch addr, store_data, dest_reg and op, clear timeout counter, go to REQ.
  - Both or neither op set: pulse err, stay IDLE.
  - Misaligned address: pulse err, stay IDLE, no RAM request.
- start while busy: ignored, with no err.
- REQ:
  - mem_req=1; mem_we, mem_addr and mem_wdata driven from latched values.
  - Counter increments each REQ cycle.
  - On mem_ack: load → capture mem_rdata into ld_data, go to CAPT; store → go to DONE.
  - Counter reaching TIMEOUT without ack: pulse err, drop mem_req, go to IDLE.
  - If ack and timeout coincide, ack wins.
- CAPT: ld_sel=1, ld_data stable. The mux samples on this cycle's closing edge.
- WB: ld_sel=1, wb_en=1, wb_reg=latched dest_reg, done=1. Then go to IDLE.
- DONE (stores only): done=1 for one cycle. Then go to IDLE.
- ld_sel drops to 0 on entry to IDLE.
- ld_data holds its last captured value until the next load.
- wb_en is never asserted for stores or on error.
- Reset values: all outputs 0, state IDLE, counter 0. Reset mid-operation drops mem_req immediately and discards the transaction.

## Timing
- Load: start sampled at edge 0 → REQ from cycle 1. With ack in cycle k: CAPT in cycle k+1, WB/done in cycle k+2. Zero-wait RAM (ack in cycle 1) gives done in cycle 3.
- Store: ack in cycle k → done in cycle k+1.
- mem_req is registered (no combinational path from start). mem_ack is not expected in the same cycle as the start edge.
- err is a registered pulse, one cycle after the offending start or at the timeout cycle.
- Back-to-back: a new start is accepted in the cycle after done.

## Structure
- Shared package: state enum (IDLE/REQ/CAPT/WB/DONE), op encoding, register-index width constant (4).
- Sub-module: lsu_timeout_ctr, a loadable up-counter with clear and a terminal flag at TIMEOUT, instantiated once.
- The FSM and datapath latches stay in load_store_unit.

## Test plan
- Load with zero-wait RAM:
  - Stimulus: start, is_load, addr=0x10, dest_reg=3; mem_ack in cycle 1 with mem_rdata=0xDEADBEEF.
  - Required: ld_data=0xDEADBEEF in CAPT; wb_en, wb_reg=3 and done in cycle 3; ld_sel=0 in cycle 4.
- Store with 4-cycle wait:
  - Stimulus: addr=0x20, store_data=0x12345678, ack in cycle 4.
  - Required: mem_req high cycles 1–4 with mem_we=1 and mem_wdata=0x12345678; done in cycle 5; wb_en never high.
- Timeout:
  - Stimulus: TIMEOUT=8, no ack.
  - Required: err pulse after 8 REQ cycles, mem_req low the next cycle, busy=0.
- Illegal starts:
  - Stimulus: is_load=is_store=1; separately, addr=0x13.
  - Required: err pulse each time, mem_req never asserted.
- Reset mid-load:
  - Stimulus: assert rst_n=0 during REQ.
  - Required: mem_req, busy and ld_sel drop at once; after release, a fresh load completes normally.
- Start while busy:
  - Stimulus: second start during REQ.
  - Required: ignored; exactly one done pulse.
